// File: rtl/chsub_pkg.sv
// -----------------------------------------------------------------------------
// chsub_pkg
// Shared definitions for the chunked subtractor (chunked_sub):
//   SLICE_W   - bits handled per clock by the borrow-lookahead slice
//   state_t   - controller states (IDLE / RUN / DONE)
//   nslice()  - number of slices for a given operand width
//   idx_width() - width of the slice index register ($clog2(NSLICE), min 1)
// Optional feature macro used by the top: CHSUB_OVF_EN (signed overflow flag).
// -----------------------------------------------------------------------------
package chsub_pkg;

   localparam int SLICE_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int nslice(input int width);
      return width / SLICE_W;
   endfunction

   // A single-slice build still needs a 1-bit index so the register exists.
   function automatic int idx_width(input int width);
      int n;
      n = width / SLICE_W;
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/chunked_sub_bla_slice4.sv
// -----------------------------------------------------------------------------
// bla_slice4
// Combinational 4-bit borrow-lookahead subtract slice: d4 = a4 - b4 - bi.
// Ports:
//   a4 [3:0] in  - minuend slice
//   b4 [3:0] in  - subtrahend slice
//   bi       in  - borrow into bit 0
//   d4 [3:0] out - difference slice
//   bo       out - borrow out of bit 3
// Borrow generate bg = ~a & b (this bit borrows on its own), borrow propagate
// bp = ~a | b (this bit passes an incoming borrow on). All four internal
// borrows are flattened sum-of-products of bg/bp/bi, so no bit waits on the
// previous bit's borrow.
// -----------------------------------------------------------------------------
module bla_slice4 (
   input  logic [3:0] a4,
   input  logic [3:0] b4,
   input  logic       bi,
   output logic [3:0] d4,
   output logic       bo
);

   logic [3:0] bg;
   logic [3:0] bp;
   logic [4:0] c;

   assign bg = ~a4 & b4;
   assign bp = ~a4 | b4;

   assign c[0] = bi;
   assign c[1] = bg[0]
               | (bp[0] & bi);
   assign c[2] = bg[1]
               | (bp[1] & bg[0])
               | (bp[1] & bp[0] & bi);
   assign c[3] = bg[2]
               | (bp[2] & bg[1])
               | (bp[2] & bp[1] & bg[0])
               | (bp[2] & bp[1] & bp[0] & bi);
   assign c[4] = bg[3]
               | (bp[3] & bg[2])
               | (bp[3] & bp[2] & bg[1])
               | (bp[3] & bp[2] & bp[1] & bg[0])
               | (bp[3] & bp[2] & bp[1] & bp[0] & bi);

   assign d4 = a4 ^ b4 ^ c[3:0];
   assign bo = c[4];

endmodule

// File: rtl/chunked_sub.sv
// -----------------------------------------------------------------------------
// chunked_sub
// Multi-cycle WIDTH-bit subtractor: diff = a - b - bin (mod 2^WIDTH), one
// 4-bit borrow-lookahead slice per clock, LSB slice first. A single slice
// instance is shared across all slice positions through an index mux; the
// borrow between slices is carried in one flop.
//
// Optional feature: define CHSUB_OVF_EN to add the signed-overflow output ovf.
//
// Ports:
//   clk, rst_n          - clock (rising edge), async active-low reset
//   in_valid / in_ready - operand handshake (a, b, bin)
//   a, b [WIDTH-1:0]    - minuend, subtrahend
//   bin                 - borrow in
//   out_valid/out_ready - result handshake (diff, bout, ovf)
//   diff [WIDTH-1:0]    - a - b - bin
//   bout                - 1 iff unsigned a < b + bin
//   ovf                 - signed overflow (CHSUB_OVF_EN only)
//   state, idx          - debug view of the controller state and slice index
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. Operands are sampled only on that accept edge; in_ready is 1 only
// in IDLE, so in_valid while busy is ignored (the producer must hold it).
// out_valid rises NSLICE edges after accept and, with diff/bout/ovf, is held
// until the edge where out_ready is 1; out_ready with out_valid low is a
// no-op. There is no same-cycle re-accept on the consume edge.
// -----------------------------------------------------------------------------
module chunked_sub
   import chsub_pkg::*;
#(
   parameter  int WIDTH = 16,
   localparam int NSLICE = nslice(WIDTH),
   localparam int IDX_W  = idx_width(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
`ifdef CHSUB_OVF_EN
   output logic             ovf,
`endif
   output state_t           state,
   output logic [IDX_W-1:0] idx
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   b_q;
   logic               borrow_q;

   logic [SLICE_W-1:0] a4;
   logic [SLICE_W-1:0] b4;
   logic [SLICE_W-1:0] d4;
   logic               c4;

   // Select the operand slice addressed by idx.
   always_comb begin
      a4 = '0;
      b4 = '0;
      for (int i = 0; i < NSLICE; i++) begin
         if (idx == IDX_W'(i)) begin
            a4 = a_q[i*SLICE_W +: SLICE_W];
            b4 = b_q[i*SLICE_W +: SLICE_W];
         end
      end
   end

   bla_slice4 u_slice (
      .a4 (a4),
      .b4 (b4),
      .bi (borrow_q),
      .d4 (d4),
      .bo (c4)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         idx       <= '0;
         a_q       <= '0;
         b_q       <= '0;
         borrow_q  <= 1'b0;
         diff      <= '0;
         bout      <= 1'b0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
`ifdef CHSUB_OVF_EN
         ovf       <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               // diff/bout keep the last result until a new op overwrites them.
               if (in_valid && in_ready) begin
                  a_q      <= a;
                  b_q      <= b;
                  borrow_q <= bin;
                  idx      <= '0;
                  in_ready <= 1'b0;
                  state    <= RUN;
               end
            end

            RUN: begin
               for (int i = 0; i < NSLICE; i++) begin
                  if (idx == IDX_W'(i)) begin
                     diff[i*SLICE_W +: SLICE_W] <= d4;
                  end
               end
               borrow_q <= c4;
               if (idx == LAST_IDX) begin
                  bout      <= c4;
`ifdef CHSUB_OVF_EN
                  // Operands of opposite sign and result sign differs from a.
                  ovf       <= (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (d4[SLICE_W-1] ^ a_q[WIDTH-1]);
`endif
                  idx       <= '0;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end

            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end

            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_chunked_sub.sv
// -----------------------------------------------------------------------------
// tb_chunked_sub
// Self-checking bench for chunked_sub (WIDTH=16). Directed cases plus random
// operations are compared against an arithmetic reference model. Define
// CHSUB_OVF_EN for both bench and design to also check ovf.
// -----------------------------------------------------------------------------
module tb_chunked_sub;
   import chsub_pkg::*;

   localparam int W  = 16;
   localparam int NS = W / 4;

   // ---------------- clock / reset / DUT ----------------
   logic                    clk = 1'b0;
   logic                    rst_n = 1'b1;
   logic                    in_valid = 1'b0;
   logic                    out_ready = 1'b0;
   logic                    bin = 1'b0;
   logic [W-1:0]            a = '0;
   logic [W-1:0]            b = '0;
   logic                    in_ready;
   logic                    out_valid;
   logic                    bout;
   logic [W-1:0]            diff;
   state_t                  state;
   logic [idx_width(W)-1:0] idx;
`ifdef CHSUB_OVF_EN
   logic                    ovf;
`endif

   int compared   = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   chunked_sub #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .bin       (bin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .bout      (bout),
`ifdef CHSUB_OVF_EN
      .ovf       (ovf),
`endif
      .state     (state),
      .idx       (idx)
   );

   initial begin
      #500000;
      $display("FAIL watchdog: observed no finish, expected finish before 500us");
      $fatal(1, "watchdog expired");
   end

   // ---------------- scoreboard ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference model: plain integer arithmetic.
   function automatic logic [W-1:0] ref_diff(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
      int r;
      r = int'(x) - int'(y) - int'(c);
      return r[W-1:0];
   endfunction

   function automatic logic ref_bout(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
      return (int'(x) < int'(y) + int'(c));
   endfunction

   function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
      int sr;
      sr = int'($signed(x)) - int'($signed(y)) - int'(c);
      return (sr < -(1 << (W-1))) || (sr > (1 << (W-1)) - 1);
   endfunction

   // ---------------- driver ----------------
   // One full operation: accept, count edges to out_valid, check result,
   // optionally stall the consumer, then consume.
   task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                         input int stall, input bit busy_pulse, input string tag);
      logic [W-1:0] ed;
      logic         eb;
      int           n;
      ed = ref_diff(x, y, c);
      eb = ref_bout(x, y, c);

      @(negedge clk);
      a         = x;
      b         = y;
      bin       = c;
      in_valid  = 1'b1;
      out_ready = (stall == 0);
      check({tag, "_acc_ready"}, 32'(in_ready), 32'd1);

      @(posedge clk); #1;
      // Operands after the accept edge must have no effect.
      in_valid = busy_pulse;
      a        = W'($urandom);
      b        = W'($urandom);
      bin      = 1'($urandom);

      n = 0;
      while (out_valid !== 1'b1 && n < 40) begin
         check({tag, "_busy_ready"}, 32'(in_ready), 32'd0);
         @(posedge clk); #1;
         n++;
      end
      in_valid = 1'b0;

      check({tag, "_latency"}, 32'(n), 32'(NS));
      check({tag, "_diff"}, 32'(diff), 32'(ed));
      check({tag, "_bout"}, 32'(bout), 32'(eb));
`ifdef CHSUB_OVF_EN
      check({tag, "_ovf"}, 32'(ovf), 32'(ref_ovf(x, y, c)));
`endif
      check({tag, "_done_ready"}, 32'(in_ready), 32'd0);

      for (int k = 0; k < stall; k++) begin
         @(posedge clk); #1;
         check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
         check({tag, "_hold_diff"}, 32'(diff), 32'(ed));
         check({tag, "_hold_ready"}, 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;

      @(posedge clk); #1;
      check({tag, "_consumed_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_consumed_ready"}, 32'(in_ready), 32'd1);
      check({tag, "_consumed_state"}, 32'(state), 32'(IDLE));
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      logic [W-1:0] rx, ry;
      logic         rc;

      // Reset values, applied asynchronously.
      #2 rst_n = 1'b0;
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_diff", 32'(diff), 32'd0);
      check("rst_bout", 32'(bout), 32'd0);
      check("rst_state", 32'(state), 32'(IDLE));
      check("rst_idx", 32'(idx), 32'd0);
`ifdef CHSUB_OVF_EN
      check("rst_ovf", 32'(ovf), 32'd0);
`endif
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;

      // out_ready while idle: nothing happens.
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("idle_ordy_valid", 32'(out_valid), 32'd0);
      check("idle_ordy_ready", 32'(in_ready), 32'd1);

      run_op(16'h1234, 16'h0234, 1'b0, 0, 1'b0, "simple");
      run_op(16'h0000, 16'h0001, 1'b0, 0, 1'b0, "underflow");
      run_op(16'h0005, 16'h0005, 1'b1, 0, 1'b0, "eq_bin1");
      run_op(16'h5A5A, 16'h5A5A, 1'b0, 0, 1'b0, "eq_bin0");
      run_op(16'hABCD, 16'h1111, 1'b0, 10, 1'b0, "backpressure");
      run_op(16'h0010, 16'h0001, 1'b0, 0, 1'b1, "busy_change");
      run_op(16'h8000, 16'h0001, 1'b0, 0, 1'b0, "ovf_neg");
      run_op(16'h7FFF, 16'hFFFF, 1'b0, 0, 1'b0, "ovf_pos");
      run_op(16'h0005, 16'h0003, 1'b0, 0, 1'b0, "no_ovf");

      // Reset in the middle of RUN: aborts immediately, no result.
      @(negedge clk);
      a = 16'hF0F0; b = 16'h0F0F; bin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_in_ready", 32'(in_ready), 32'd1);
      check("midrst_diff", 32'(diff), 32'd0);
      check("midrst_state", 32'(state), 32'(IDLE));
      check("midrst_idx", 32'(idx), 32'd0);
      @(negedge clk) rst_n = 1'b1;
      repeat (NS + 2) begin
         @(posedge clk); #1;
         check("midrst_no_result", 32'(out_valid), 32'd0);
      end
      run_op(16'h0003, 16'h0001, 1'b0, 0, 1'b0, "after_rst");

      // Reset while holding a result in DONE.
      @(negedge clk);
      a = 16'h4321; b = 16'h0021; bin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (NS + 1) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("donerst_out_valid", 32'(out_valid), 32'd0);
      check("donerst_diff", 32'(diff), 32'd0);
      check("donerst_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk) rst_n = 1'b1;

      // Random operations with random consumer stalls.
      for (int t = 0; t < 60; t++) begin
         rx = W'($urandom);
         ry = W'($urandom);
         rc = 1'($urandom);
         if (t % 10 == 0) ry = rx;
         run_op(rx, ry, rc, $urandom_range(0, 3), 1'($urandom), "rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
